// File: rtl/psum_lif_sched_pkg.sv
// -----------------------------------------------------------------------------
// psum_lif_sched_pkg
//   Shared definitions for the psum-RAM -> LIF readout scheduler:
//   - default widths and timing constants (PSUM_W follows the ERS max width)
//   - the scheduler state enum
//   - the post-stream GAP length (RAM_LAT + 1)
// -----------------------------------------------------------------------------
`ifndef ERS_MAX_WIDTH
`define ERS_MAX_WIDTH 20
`endif

package psum_lif_sched_pkg;

    localparam int ADDR_W_DEF    = 12;
    localparam int CH_W_DEF      = 8;
    localparam int PSUM_W_DEF    = `ERS_MAX_WIDTH;
    localparam int RAM_LAT_DEF   = 1;
    localparam int DRAIN_CYC_DEF = 16;

    // The last line's data needs RAM_LAT cycles to come out of the RAM plus
    // one more for the bias add, so the bias must be held that long.
    localparam int GAP_CYC_DEF = RAM_LAT_DEF + 1;

    function automatic int gap_cycles(input int ram_lat);
        return ram_lat + 1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STREAM,
        ST_GAP,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/psum_rd_delay.sv
// -----------------------------------------------------------------------------
// psum_rd_delay
//   DEPTH-stage shift register that turns the psum RAM read strobe into the
//   LIF line request, aligned with the RAM read data.
//   Ports:
//     clk   in  : clock
//     clr_n in  : synchronous active-low clear (empties the pipe)
//     din   in  : read strobe
//     dout  out : din delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module psum_rd_delay
    import psum_lif_sched_pkg::*;
#(
    parameter int DEPTH = RAM_LAT_DEF
) (
    input  logic clk,
    input  logic clr_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] taps;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            taps <= '0;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/psum_lif_sched.sv
// -----------------------------------------------------------------------------
// psum_lif_sched
//   Readout scheduler for the psum-RAM -> LIF -> spike-organize path. After a
//   layer has accumulated, walks every output channel: fetches its bias,
//   streams img_size psum lines, holds the bias until the last line has used
//   it, and pulses done once the LIF pipeline has drained.
//   Ports:
//     s_clk, s_rst_n          : clock, synchronous active-low reset
//     code_valid, cfg_*       : layer config strobe and fields (IDLE only)
//     start                   : begin readout (IDLE, code_valid low)
//     busy, done              : busy from accepted start; done pulse at end
//     bias_req/bias_ch        : bias fetch request, held until bias_ack
//     bias_ack/bias_data      : returned bias
//     ram_rd_en/ram_rd_addr   : psum RAM read port
//     dn_ready                : downstream can accept; gates reads
//     lif_line_req            : ram_rd_en delayed by RAM_LAT
//     lif_bias                : bias of the channel being streamed
//     lif_code_valid/lif_thrd/lif_img_size : LIF/organize config
// -----------------------------------------------------------------------------
module psum_lif_sched
    import psum_lif_sched_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int CH_W      = CH_W_DEF,
    parameter int PSUM_W    = PSUM_W_DEF,
    parameter int RAM_LAT   = RAM_LAT_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic              s_clk,
    input  logic              s_rst_n,
    input  logic              code_valid,
    input  logic [15:0]       cfg_img_size,
    input  logic [CH_W-1:0]   cfg_ch_num,
    input  logic [15:0]       cfg_lif_thrd,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              bias_req,
    output logic [CH_W-1:0]   bias_ch,
    input  logic              bias_ack,
    input  logic [PSUM_W-1:0] bias_data,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic              dn_ready,
    output logic              lif_line_req,
    output logic [PSUM_W-1:0] lif_bias,
    output logic              lif_code_valid,
    output logic [15:0]       lif_thrd,
    output logic [15:0]       lif_img_size
);

    localparam int          GAP_CYC    = gap_cycles(RAM_LAT);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYC - 1);

    state_t state, state_nx;

    logic [CH_W-1:0]   ch_num_q;
    logic [CH_W-1:0]   ch_cnt;
    logic [15:0]       line_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [15:0]       wait_cnt;
    logic              done_q;

    logic cfg_load, accept, zero_layer, issue;
    logic last_line, last_ch, gap_end, drain_end;

    // busy also covers the done cycle so busy and done fall together and a
    // start in that cycle is not taken.
    assign busy       = (state != ST_IDLE) || done_q;
    assign done       = done_q;
    assign cfg_load   = code_valid && !busy;
    assign accept     = start && !code_valid && !busy;
    assign zero_layer = (lif_img_size == 16'd0) || (ch_num_q == '0);
    assign last_line  = (line_cnt == lif_img_size - 16'd1);
    assign last_ch    = (ch_cnt == ch_num_q - CH_W'(1));
    assign gap_end    = (wait_cnt == GAP_LAST);
    assign drain_end  = (wait_cnt == DRAIN_LAST);
    assign issue      = ram_rd_en;
    assign bias_ch    = ch_cnt;
    assign ram_rd_addr = addr_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        bias_req  = 1'b0;
        ram_rd_en = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept && !zero_layer) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                bias_req = 1'b1;
                if (bias_ack) state_nx = ST_STREAM;
            end
            ST_STREAM: begin
                ram_rd_en = dn_ready;
                if (dn_ready && last_line) state_nx = ST_GAP;
            end
            ST_GAP: begin
                if (gap_end) state_nx = last_ch ? ST_DRAIN : ST_FETCH;
            end
            ST_DRAIN: begin
                if (drain_end) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            ch_num_q       <= '0;
            ch_cnt         <= '0;
            line_cnt       <= '0;
            addr_cnt       <= '0;
            wait_cnt       <= '0;
            done_q         <= 1'b0;
            lif_bias       <= '0;
            lif_code_valid <= 1'b0;
            lif_thrd       <= '0;
            lif_img_size   <= '0;
        end else begin
            lif_code_valid <= cfg_load;
            // Empty layers finish the cycle after accept without any reads.
            done_q <= (accept && zero_layer) || (state == ST_DRAIN && drain_end);

            // The latched config doubles as the running config; it cannot
            // change while busy, so it stays frozen for the layer.
            if (cfg_load) begin
                lif_thrd     <= cfg_lif_thrd;
                lif_img_size <= cfg_img_size;
                ch_num_q     <= cfg_ch_num;
            end

            if (accept) begin
                ch_cnt   <= '0;
                line_cnt <= '0;
                addr_cnt <= '0;
            end

            if (state == ST_FETCH && bias_ack) lif_bias <= bias_data;

            // Address keeps running across channels and wraps naturally.
            if (issue) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
                line_cnt <= last_line ? 16'd0 : line_cnt + 16'd1;
            end

            if (state == ST_GAP && gap_end && !last_ch) ch_cnt <= ch_cnt + CH_W'(1);

            // Shared cycle counter for GAP and DRAIN, restarted on every
            // state change.
            if (state_nx != state) begin
                wait_cnt <= '0;
            end else if (state == ST_GAP || state == ST_DRAIN) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    psum_rd_delay #(
        .DEPTH (RAM_LAT)
    ) u_rd_delay (
        .clk   (s_clk),
        .clr_n (s_rst_n),
        .din   (ram_rd_en),
        .dout  (lif_line_req)
    );

endmodule

// File: tb/tb_psum_lif_sched.sv
// -----------------------------------------------------------------------------
// tb_psum_lif_sched
//   Scoreboard bench: each layer launch pushes the expected read sequence,
//   bias requests and config pulses; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_psum_lif_sched;

    localparam int ADDR_W    = 12;
    localparam int CH_W      = 8;
    localparam int PSUM_W    = 20;
    localparam int RAM_LAT   = 1;
    localparam int DRAIN_CYC = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              code_valid = 1'b0;
    logic [15:0]       cfg_img_size = '0;
    logic [CH_W-1:0]   cfg_ch_num = '0;
    logic [15:0]       cfg_lif_thrd = '0;
    logic              start = 1'b0;
    logic              busy, done, bias_req, ram_rd_en, lif_line_req, lif_code_valid;
    logic [CH_W-1:0]   bias_ch;
    logic              bias_ack = 1'b0;
    logic [PSUM_W-1:0] bias_data = '0;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic              dn_ready = 1'b1;
    logic [PSUM_W-1:0] lif_bias;
    logic [15:0]       lif_thrd, lif_img_size;

    psum_lif_sched #(
        .ADDR_W(ADDR_W), .CH_W(CH_W), .PSUM_W(PSUM_W),
        .RAM_LAT(RAM_LAT), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .s_clk(clk), .s_rst_n(rst_n), .code_valid(code_valid),
        .cfg_img_size(cfg_img_size), .cfg_ch_num(cfg_ch_num), .cfg_lif_thrd(cfg_lif_thrd),
        .start(start), .busy(busy), .done(done), .bias_req(bias_req), .bias_ch(bias_ch),
        .bias_ack(bias_ack), .bias_data(bias_data), .ram_rd_en(ram_rd_en),
        .ram_rd_addr(ram_rd_addr), .dn_ready(dn_ready), .lif_line_req(lif_line_req),
        .lif_bias(lif_bias), .lif_code_valid(lif_code_valid), .lif_thrd(lif_thrd),
        .lif_img_size(lif_img_size)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [PSUM_W-1:0] bias;
        bit                last_ch;
        bit                last_layer;
    } rd_t;

    typedef struct {
        logic [15:0] thrd;
        logic [15:0] img;
        int          at;
    } cfg_t;

    rd_t  exp_rd_q[$];
    int   rd_cyc_q[$];
    int   exp_ch_q[$];
    cfg_t exp_cfg_q[$];
    int   exp_req_cyc  = -1;
    int   exp_done_cyc = -1;
    int   done_cnt     = 0;
    int   checks       = 0;
    int   failures     = 0;
    int   cur_thrd     = 0;

    logic [PSUM_W-1:0] bias_tbl [0:63];

    // responder / ready-generator controls
    int dn_mode   = 0;
    int pat_idx   = 0;
    int ack_delay = 1;
    int ack_wait  = 0;
    int resp_idx  = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- downstream ready pattern ----------------
    always begin
        @(posedge clk);
        #1;
        case (dn_mode)
            0:       dn_ready = 1'b1;
            1: begin dn_ready = (pat_idx % 3 == 0); pat_idx++; end
            default: dn_ready = ($urandom_range(3) != 0);
        endcase
    end

    // ---------------- bias responder ----------------
    always begin
        @(posedge clk);
        #1;
        if (bias_ack) begin
            bias_ack = 1'b0;
            ack_wait = 0;
        end else if (bias_req) begin
            if (ack_wait >= ack_delay) begin
                bias_ack  = 1'b1;
                bias_data = bias_tbl[resp_idx];
                resp_idx++;
            end else begin
                ack_wait++;
            end
        end
    end

    // ---------------- monitor ----------------
    rd_t               mon_r;
    int                mon_c;
    cfg_t              mon_cfg;
    bit                prev_rst = 1'b1;
    bit                prev_ack = 1'b0;
    bit                prev_req = 1'b0;
    bit                prev_done = 1'b0;
    logic [CH_W-1:0]   prev_ch = '0;
    logic [PSUM_W-1:0] prev_ack_data = '0;
    logic [PSUM_W-1:0] prev_bias = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rst  = 1'b1;
            prev_ack  = 1'b0;
            prev_req  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_rst)
                check({busy, done, bias_req, bias_ch, ram_rd_en, ram_rd_addr, lif_line_req,
                       lif_bias, lif_code_valid, lif_thrd, lif_img_size} == '0,
                      "outputs_after_reset",
                      $countones({busy, done, bias_req, bias_ch, ram_rd_en, ram_rd_addr,
                                  lif_line_req, lif_bias, lif_code_valid, lif_thrd,
                                  lif_img_size}), 0);

            if (ram_rd_en) begin
                if (exp_rd_q.size() == 0) begin
                    check(1'b0, "unexpected_read", ram_rd_addr, -1);
                end else begin
                    mon_r = exp_rd_q.pop_front();
                    check(ram_rd_addr == mon_r.addr, "rd_addr", ram_rd_addr, mon_r.addr);
                    check(lif_bias == mon_r.bias, "bias_at_read",
                          $signed(lif_bias), $signed(mon_r.bias));
                    check(dn_ready, "read_needs_ready", dn_ready, 1);
                    rd_cyc_q.push_back(cyc);
                    if (mon_r.last_layer) exp_done_cyc = cyc + RAM_LAT + 2 + DRAIN_CYC;
                    else if (mon_r.last_ch) exp_req_cyc = cyc + RAM_LAT + 2;
                end
            end

            if (lif_line_req) begin
                if (rd_cyc_q.size() == 0) begin
                    check(1'b0, "unexpected_line_req", 1, 0);
                end else begin
                    mon_c = rd_cyc_q.pop_front();
                    check(cyc - mon_c == RAM_LAT, "line_req_latency", cyc - mon_c, RAM_LAT);
                end
            end

            if (bias_req && !prev_req) begin
                if (exp_ch_q.size() == 0) begin
                    check(1'b0, "unexpected_bias_req", bias_ch, -1);
                end else begin
                    mon_c = exp_ch_q.pop_front();
                    check(bias_ch == CH_W'(mon_c), "bias_ch", bias_ch, mon_c);
                    check(cyc == exp_req_cyc, "bias_req_time", cyc, exp_req_cyc);
                end
            end
            if (bias_req && prev_req && bias_ch != prev_ch)
                check(1'b0, "bias_ch_stable", bias_ch, prev_ch);
            if (bias_req && ram_rd_en)
                check(1'b0, "read_before_ack", ram_rd_en, 0);

            if (prev_ack)
                check(lif_bias == prev_ack_data, "lif_bias_load",
                      $signed(lif_bias), $signed(prev_ack_data));
            else if (!prev_rst && lif_bias != prev_bias)
                check(1'b0, "lif_bias_held", $signed(lif_bias), $signed(prev_bias));

            if (lif_code_valid) begin
                if (exp_cfg_q.size() == 0) begin
                    check(1'b0, "unexpected_lif_code_valid", lif_thrd, -1);
                end else begin
                    mon_cfg = exp_cfg_q.pop_front();
                    check(cyc == mon_cfg.at, "cfg_pulse_time", cyc, mon_cfg.at);
                    check(lif_thrd == mon_cfg.thrd, "lif_thrd", lif_thrd, mon_cfg.thrd);
                    check(lif_img_size == mon_cfg.img, "lif_img_size", lif_img_size, mon_cfg.img);
                end
            end

            if (prev_done) check(!busy, "busy_falls_with_done", busy, 0);

            if (done) begin
                done_cnt++;
                if (exp_done_cyc < 0) check(1'b0, "unexpected_done", cyc, -1);
                else check(cyc == exp_done_cyc, "done_time", cyc, exp_done_cyc);
                exp_done_cyc = -1;
            end

            prev_rst      = 1'b0;
            prev_ack      = bias_ack && bias_req;
            prev_ack_data = bias_data;
            prev_req      = bias_req;
            prev_ch       = bias_ch;
            prev_done     = done;
            prev_bias     = lif_bias;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic configure(input int img, input int chn, input int thrd, input bit with_start);
        code_valid   = 1'b1;
        cfg_img_size = 16'(img);
        cfg_ch_num   = CH_W'(chn);
        cfg_lif_thrd = 16'(thrd);
        start        = with_start;
        exp_cfg_q.push_back('{thrd: 16'(thrd), img: 16'(img), at: cyc + 1});
        cur_thrd = thrd;
        step();
        code_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic launch(input int img, input int chn, input int mode, input int ack_dly);
        rd_t r;
        configure(img, chn, $urandom_range(16'h3f), 1'b0);
        if (img > 0 && chn > 0) begin
            for (int c = 0; c < chn; c++) begin
                exp_ch_q.push_back(c);
                for (int l = 0; l < img; l++) begin
                    r.addr       = ADDR_W'((c * img + l) % (1 << ADDR_W));
                    r.bias       = bias_tbl[c];
                    r.last_ch    = (l == img - 1);
                    r.last_layer = r.last_ch && (c == chn - 1);
                    exp_rd_q.push_back(r);
                end
            end
        end
        dn_mode   = mode;
        pat_idx   = 0;
        ack_delay = ack_dly;
        ack_wait  = 0;
        resp_idx  = 0;
        start     = 1'b1;
        if (img == 0 || chn == 0) exp_done_cyc = cyc + 1;
        else exp_req_cyc = cyc + 1;
        step();
        start = 1'b0;
    endtask

    task automatic finish_layer(input int budget, input bit busy_cfg);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            code_valid = busy_cfg && (i == 3);
            cfg_lif_thrd = 16'h0040;
            step();
        end
        code_valid = 1'b0;
        check(done_cnt == d0 + 1, "done_seen", done_cnt - d0, 1);
        repeat (4) step();
        check(done_cnt == d0 + 1, "single_done", done_cnt - d0, 1);
        check(exp_rd_q.size() == 0, "all_reads_issued", exp_rd_q.size(), 0);
        check(rd_cyc_q.size() == 0, "all_line_reqs", rd_cyc_q.size(), 0);
        check(exp_ch_q.size() == 0, "all_bias_reqs", exp_ch_q.size(), 0);
        check(lif_thrd == 16'(cur_thrd), "thrd_frozen", lif_thrd, cur_thrd);
    endtask

    task automatic run_layer(input int img, input int chn, input int mode, input int ack_dly,
                             input bit busy_cfg);
        launch(img, chn, mode, ack_dly);
        finish_layer(img * chn * 8 + chn * (ack_dly + 12) + DRAIN_CYC + 60, busy_cfg);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d0;
        for (int i = 0; i < 64; i++) bias_tbl[i] = PSUM_W'($urandom);

        repeat (3) step();
        rst_n = 1'b1;
        step();

        // start together with code_valid is ignored, config still taken
        configure(4, 2, 16'h0010, 1'b1);
        repeat (20) step();
        check(!busy, "start_with_cfg_ignored", busy, 0);

        // basic two-channel layer, biases 5 then -3, code_valid while busy
        bias_tbl[0] = PSUM_W'(5);
        bias_tbl[1] = PSUM_W'(-3);
        run_layer(4, 2, 0, 1, 1'b1);

        // ignored busy config must not have leaked; now take 0x40 in IDLE
        configure(4, 2, 16'h0040, 1'b0);
        step();

        // stalling downstream 1,0,0,...
        run_layer(4, 2, 1, 1, 1'b0);

        // empty layers
        run_layer(0, 3, 0, 1, 1'b0);
        run_layer(5, 0, 0, 1, 1'b0);

        // slow bias acknowledge
        run_layer(3, 3, 0, 5, 1'b0);

        // reset in the middle of streaming, at address 3
        launch(4, 2, 0, 1);
        for (int i = 0; i < 40 && !(ram_rd_en && ram_rd_addr == 3); i++) step();
        check(ram_rd_en && ram_rd_addr == 3, "reached_addr3", ram_rd_addr, 3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_rd_q.delete();
        rd_cyc_q.delete();
        exp_ch_q.delete();
        exp_cfg_q.delete();
        exp_done_cyc = -1;
        exp_req_cyc  = -1;
        d0 = done_cnt;
        repeat (40) step();
        check(done_cnt == d0, "no_done_after_reset", done_cnt - d0, 0);
        check(!busy, "idle_after_reset", busy, 0);
        run_layer(4, 2, 0, 1, 1'b0);

        // randomized layers
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 64; i++) bias_tbl[i] = PSUM_W'($urandom);
            run_layer($urandom_range(1, 12), $urandom_range(1, 5),
                      $urandom_range(0, 2), $urandom_range(0, 4), 1'b0);
        end

        // address wraps past 2^ADDR_W
        run_layer(100, 45, 2, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/psum_lif_sched.md
# psum_lif_sched

Readout scheduler for the psum-RAM → LIF → spike-organize path. After a convolution layer has fully accumulated its partial sums, the block walks every output channel: it fetches the channel's bias, streams `img_size` psum lines out of the psum RAM, and drives the `conv_bias_ext`, `read_1line_req`, threshold and image-size inputs of the LIF datapath. It holds the bias stable until the last line of a channel has consumed it, and signals completion only after the LIF pipeline has drained.

## Interface
- `ADDR_W`, 12, psum RAM line-address width
- `CH_W`, 8, channel-count width
- `PSUM_W`, 20, psum/bias width (equals ERS max width)
- `RAM_LAT`, 1, psum RAM read latency in cycles (≥1)
- `DRAIN_CYC`, 16, cycles from last `lif_line_req` until the last spike line leaves the LIF/organize pipeline
- `s_clk` in 1: clock
- `s_rst_n` in 1: synchronous, active-low reset
- `code_valid` in 1: layer config strobe
- `cfg_img_size` in 16: lines per channel
- `cfg_ch_num` in CH_W: number of output channels
- `cfg_lif_thrd` in 16: LIF threshold
- `start` in 1: psum accumulation complete, begin readout
- `busy` out 1: high from accepted start until `done`
- `done` out 1: one-cycle completion pulse
- `bias_req` out 1, `bias_ch` out CH_W: bias fetch request and channel index
- `bias_ack` in 1, `bias_data` in PSUM_W (signed): bias returned, valid with ack
- `ram_rd_en` out 1, `ram_rd_addr` out ADDR_W: psum RAM read port
- `dn_ready` in 1: downstream spike FIFO can accept; reads issue only while high
- `lif_line_req` out 1: `ram_rd_en` delayed RAM_LAT, aligned with RAM data
- `lif_bias` out PSUM_W: conv bias for the current channel
- `lif_code_valid` out 1, `lif_thrd` out 16, `lif_img_size` out 16: LIF and organize config

## Operation
- States: IDLE, FETCH, STREAM, GAP, DRAIN.
- IDLE:
  - `code_valid` latches the three cfg fields; `lif_thrd` and `lif_img_size` update and `lif_code_valid` pulses on the next cycle.
  - `start` is accepted only in IDLE and only when `code_valid` is low in the same cycle; otherwise it is ignored.
  - On accept: channel counter, line counter and address counter are cleared, `busy` rises.
  - If img_size==0 or ch_num==0, go straight to the done pulse with no reads.
- FETCH: hold `bias_req`=1 with `bias_ch`=channel until `bias_ack`. On ack, register `bias_data` into `lif_bias`, drop `bias_req`, go to STREAM.
- STREAM:
  - Each cycle with `dn_ready`=1, issue `ram_rd_en` at the current address, then increment address and line count.
  - With `dn_ready`=0, `ram_rd_en` is 0 and all counters hold.
  - After line img_size−1 is issued, go to GAP.
- GAP: wait RAM_LAT+1 cycles so the final line's bias add completes.
  - If more channels remain, increment the channel and go to FETCH.
  - Otherwise go to DRAIN.
- DRAIN: wait DRAIN_CYC cycles, pulse `done`, clear `busy`, return to IDLE.
- Address is continuous across channels (ch·img_size+line) and wraps modulo 2^ADDR_W.
- `code_valid` while busy is ignored. Running config is frozen for the layer.
- `lif_bias` changes only on `bias_ack` in FETCH.

## Timing
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Latched config and `lif_bias` are 0.
  - The delay line is cleared, so no `lif_line_req` is emitted after reset.
  - Reset mid-operation aborts silently, with no `done` pulse.
- Accept `start` at cycle 0 → `bias_req`=1 at cycle 1.
- `bias_ack` at cycle k → `lif_bias` valid at k+1. The first `ram_rd_en` can occur at k+1.
- `lif_line_req` equals `ram_rd_en` exactly RAM_LAT cycles later, independent of `dn_ready`.
- Last read at cycle r → next `bias_req` at r+RAM_LAT+2; `lif_bias` is unchanged through r+RAM_LAT+1.
- Last read of the last channel at r → `done` at r+RAM_LAT+2+DRAIN_CYC.
- `done` and the `busy` fall coincide.
- Unconditional stream throughput is one line per cycle.

## Structure
- The shared package holds:
  - the state enum
  - the GAP length constant (RAM_LAT+1)
  - the default widths, with PSUM_W tied to the ERS max width macro
- One sub-module, `psum_rd_delay`: a RAM_LAT-deep shift register for `lif_line_req`, with synchronous active-low clear.

## Test plan
- img_size=4, ch_num=2, RAM_LAT=1, `dn_ready`=1, ack one cycle after req with biases 5 then −3:
  - 8 reads, addresses 0..7, `lif_line_req` one cycle after each.
  - `lif_bias` stays 5 until after the GAP, then becomes −3.
  - Exactly one `done` pulse.
- Same config with `dn_ready` toggling 1,0,0,1,…: reads stall on 0, with no skipped or duplicated addresses.
- `cfg_img_size`=0 then `start`: `done` in the cycle after accept, no `bias_req`, no `ram_rd_en`.
- `bias_ack` delayed 5 cycles: `bias_req` held, `bias_ch` stable, zero reads until the ack.
- `s_rst_n` low during STREAM at address 3: all outputs 0 next cycle, no `done`. A new `start` restarts at address 0 with channel 0.
- `code_valid` with thrd=0x40 while busy: ignored. In IDLE: `lif_code_valid` pulse and `lif_thrd`=0x40 one cycle later. A `start` in the same cycle as `code_valid` is ignored.
